// File: rtl/prod_accumulator.sv
// Sums N_TERMS unsigned 8-bit products behind valid/ready handshakes on both sides.
// Define PROD_ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module prod_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow
);

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_overflow;

  logic             w_accept;
  logic             w_last;
  logic             w_out_hs;
  logic [ACC_W:0]   w_add;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  // Bit ACC_W of the result is the carry-out; the low bits are the new sum.
  function automatic logic [ACC_W:0] add_prod(input logic [ACC_W-1:0] acc,
                                              input logic [7:0]       p);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(p);
`ifdef PROD_ACC_SATURATE_EN
    if (s[ACC_W]) s[ACC_W-1:0] = '1;
`endif
    return s;
  endfunction

  assign in_ready  = (r_state == ACCUM);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_out_hs  = r_out_valid && out_ready;
  assign w_add     = add_prod(r_acc, in_p);
  assign w_sum     = w_add[ACC_W-1:0];
  assign w_carry   = w_add[ACC_W];

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign overflow  = r_overflow;

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
        HOLD:    if (w_out_hs)           w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // clear outranks both handshakes; a beat arriving with it is dropped
      if (clear) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
        r_overflow  <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_out_sum   <= w_sum;
          r_overflow  <= r_ovf | w_carry;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 8'd1;
          r_ovf <= r_ovf | w_carry;
        end
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Downstream consumer of the 4x4 combinational multiplier (a[3:0] x b[3:0] -> p[7:0]).
- Accepts one 8-bit product per valid/ready handshake and sums N_TERMS consecutive products into a registered accumulator.
- Presents the finished sum with an overflow flag on an output valid/ready handshake, then starts the next group.
- Turns the multiplier into a dot-product / MAC stage.

Parameters:
- N_TERMS, 4, number of products summed per result; legal range 1..255.
- ACC_W, 10, accumulator and result width in bits; must be >= 8.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_p carries a valid product this cycle.
- in_ready, output, 1, block accepts a product this cycle.
- in_p, input, 8, product from the multiplier, treated as unsigned.
- clear, input, 1, synchronous abort of the current group.
- out_valid, output, 1, out_sum/overflow hold a finished result.
- out_ready, input, 1, downstream accepts the result this cycle.
- out_sum, output, ACC_W, sum of the last N_TERMS accepted products.
- overflow, output, 1, the group's sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (async, immediate on rst=1): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, overflow=0. Therefore in_ready=1 once rst is deasserted.
- in_ready = (state==ACCUM). It is decoded from state only, with no combinational path from out_ready or in_valid.
- Accept means in_valid & in_ready sampled at a rising edge.
- ACCUM, on accept with cnt < N_TERMS-1:
  - acc <= acc + zero-extended in_p; cnt <= cnt+1.
  - ovf <= ovf | carry-out of the ACC_W-bit add.
- ACCUM, on accept with cnt == N_TERMS-1:
  - out_sum <= acc+in_p; overflow <= ovf | carry; out_valid <= 1.
  - acc, cnt, ovf <= 0; state <= HOLD.
  - Latency: out_valid rises on the edge after the Nth accept.
- ACCUM with in_valid=0: no state change. Idle gaps between beats are allowed anywhere in a group.
- HOLD:
  - in_ready=0; any in_valid is ignored and not counted.
  - out_sum, overflow and out_valid stay stable until out_valid & out_ready.
  - On out_valid & out_ready: out_valid <= 0; state <= ACCUM. out_sum and overflow keep their last value.
  - This gives one bubble cycle minimum between groups; there is no bypass.
- clear=1 in any state (highest priority, wins over accept and output handshake):
  - acc, cnt, ovf <= 0; out_valid <= 0; overflow <= 0; state <= ACCUM.
  - A beat presented in the same cycle is discarded. out_sum is unchanged.
- N_TERMS=1: every accept goes straight to HOLD with out_sum=in_p.
- Arithmetic: unsigned and modulo 2^ACC_W unless the optional feature below changes it. ovf is sticky for the group and cleared at group start.
- Reset mid-group or mid-HOLD: partial sum is discarded and all outputs return to reset values asynchronously.

Optional Feature:
- Macro PROD_ACC_SATURATE_EN.
- Defined: any add that carries out clamps acc (and the final out_sum) to 2^ACC_W-1. Later adds in the same group keep it clamped. overflow is still set.
- Undefined: sum wraps modulo 2^ACC_W and overflow flags the wrap.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then beats 12,8,1,14 back-to-back with out_ready=1 -> out_valid=1 for exactly one cycle on the edge after the 4th beat, out_sum=35, overflow=0, in_ready=0 that cycle, in_ready=1 the following cycle.
- Same beats with idle gaps of 0..3 cycles between them, out_ready=0 for 5 cycles after completion -> out_sum=35 held stable all 5 cycles, in_ready=0, extra in_valid beat (value 99) ignored; next group 1,1,1,1 -> out_sum=4.
- Four beats of 225, ACC_W=10 -> out_sum=900, overflow=0.
- Four beats of 225, ACC_W=8 -> without PROD_ACC_SATURATE_EN: out_sum=132, overflow=1. With it: out_sum=255, overflow=1.
- Beats 50,60, then clear=1 together with in_valid (in_p=70), then beats 1,2,3,4 -> out_sum=10, overflow=0; the 70 is never counted.
- Assert rst asynchronously (between clock edges) while in HOLD with out_sum=35 -> out_valid, out_sum, overflow go to 0 immediately; after release, 4 beats of 2 -> out_sum=8.
